// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the registered N-to-1 scan multiplexer.
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_next_ch.sv
// Priority finder: lowest set mask bit strictly above ptr, or at/above 0 when first is set.
module mux_next_ch #(
    parameter int unsigned N_CH  = 16,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] ptr,
    input  logic             first,
    output logic [SEL_W-1:0] idx_c,
    output logic             found_c
);

    // Descending walk so the last hit written is the lowest qualifying index.
    always_comb begin
        idx_c   = '0;
        found_c = 1'b0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(ptr)))) begin
                idx_c   = SEL_W'(i);
                found_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N-to-1 channel mux with one-shot manual read and single-pass ascending scan,
// presenting each captured sample through a valid/ready handshake.
module mux_nto1_scan
    import mux_scan_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N_CH  = 16,
    parameter int unsigned SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH*WIDTH-1:0] data_in,
    input  logic [N_CH-1:0]       ch_en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel_in,
    input  logic                  start,
    input  logic                  abort,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned N_PAD = 1 << SEL_W;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic              mode_q, mode_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              pend_q, pend_d;
    logic [WIDTH-1:0]  out_data_d;
    logic [SEL_W-1:0]  out_ch_d;
    logic              out_valid_d, busy_d, done_d, err_d;

    logic [WIDTH-1:0]  ch_data [N_PAD];
    logic [N_PAD-1:0]  en_pad;
    logic [SEL_W-1:0]  nxt_idx_c;
    logic              nxt_found_c;

    // Pad to a power of two so out-of-range selects read a disabled, zero channel.
    for (genvar k = 0; k < N_PAD; k++) begin : g_ch
        if (k < N_CH) begin : g_used
            assign ch_data[k] = data_in[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch_data[k] = '0;
        end
    end

    assign en_pad = N_PAD'(ch_en);

    mux_next_ch #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_next (
        .mask    (mask_q),
        .ptr     (out_ch),
        .first   (pend_q),
        .idx_c   (nxt_idx_c),
        .found_c (nxt_found_c)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            mode_q    <= MODE_MANUAL;
            sel_q     <= '0;
            pend_q    <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            sel_q     <= sel_d;
            pend_q    <= pend_d;
            out_data  <= out_data_d;
            out_ch    <= out_ch_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    // Next-state and output logic; an accepted start arms a capture on the following edge.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        mode_d      = mode_q;
        sel_d       = sel_q;
        pend_d      = pend_q;
        out_data_d  = out_data;
        out_ch_d    = out_ch;
        out_valid_d = out_valid;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (abort) begin
            state_d     = IDLE;
            pend_d      = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mask_d = ch_en;
                        mode_d = mode;
                        sel_d  = sel_in;
                        if (mode == MODE_SCAN) begin
                            if (ch_en == '0) begin
                                err_d = 1'b1;
                            end else begin
                                state_d = HOLD;
                                pend_d  = 1'b1;
                            end
                        end else if (!en_pad[sel_in]) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = HOLD;
                            pend_d  = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (pend_q) begin
                        pend_d      = 1'b0;
                        out_valid_d = 1'b1;
                        if (mode_q == MODE_SCAN) begin
                            out_ch_d   = nxt_idx_c;
                            out_data_d = ch_data[nxt_idx_c];
                        end else begin
                            out_ch_d   = sel_q;
                            out_data_d = ch_data[sel_q];
                        end
                    end else if (out_valid && out_ready) begin
                        if ((mode_q == MODE_SCAN) && nxt_found_c) begin
                            out_ch_d   = nxt_idx_c;
                            out_data_d = ch_data[nxt_idx_c];
                        end else begin
                            out_valid_d = 1'b0;
                            done_d      = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

endmodule
